// File: rtl/priority_decoder_q.sv
// priority_decoder_q
// Queued 2-to-4 priority-code decoder. Accepts 2-bit indices over a
// valid/ready handshake, buffers them in a DEPTH-entry FIFO, and drives each
// one as a one-hot line for exactly HOLD consecutive cycles. Consecutive
// codes are replayed back to back with no gap cycle between windows.
//
// Parameters
//   DEPTH : FIFO entries (power of 2, >= 2)
//   HOLD  : cycles each one-hot value stays asserted (>= 1)
//
// Ports
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   in_code    : encoded index, 2'b00 -> line 0 ... 2'b11 -> line 3
//   in_valid   : in_code is valid
//   in_ready   : FIFO has space (combinational from fifo_count and rst)
//   out_onehot : decoded line, 4'b0000 when out_valid is low
//   out_valid  : out_onehot is driving a code
//   fifo_count : entries queued, not counting the one being driven
module priority_decoder_q #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               in_code,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [3:0]               out_onehot,
    output logic                     out_valid,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_e;

    function automatic logic [3:0] f_decode(input logic [1:0] code);
        f_decode = 4'b0001 << code;
    endfunction

    // FIFO storage and control
    logic [1:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_count;

    // Output FSM
    state_e        r_state;
    logic [HW-1:0] r_hold;
    logic [3:0]    r_onehot;
    logic          r_valid;

    state_e        w_state_nxt;
    logic [HW-1:0] w_hold_nxt;
    logic [3:0]    w_onehot_nxt;
    logic          w_valid_nxt;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;

    // Full check ignores a same-edge pop on purpose: ready never looks ahead.
    assign in_ready   = (r_count < CW'(DEPTH)) & ~rst;
    assign w_push     = in_valid & in_ready;
    assign w_empty    = (r_count == '0);

    assign out_onehot = r_onehot;
    assign out_valid  = r_valid;
    assign fifo_count = r_count;

    always_comb begin
        w_state_nxt  = r_state;
        w_hold_nxt   = r_hold;
        w_onehot_nxt = r_onehot;
        w_valid_nxt  = r_valid;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                w_onehot_nxt = 4'b0000;
                w_valid_nxt  = 1'b0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_onehot_nxt = f_decode(r_mem[r_rd]);
                    w_valid_nxt  = 1'b1;
                    w_hold_nxt   = HW'(HOLD - 1);
                    w_state_nxt  = DRIVE;
                end
            end
            DRIVE: begin
                if (r_hold != '0) begin
                    w_hold_nxt = r_hold - HW'(1);
                end else if (!w_empty) begin
                    // Window expired with work pending: chain straight into
                    // the next code so the line never drops between windows.
                    w_pop        = 1'b1;
                    w_onehot_nxt = f_decode(r_mem[r_rd]);
                    w_valid_nxt  = 1'b1;
                    w_hold_nxt   = HW'(HOLD - 1);
                end else begin
                    w_onehot_nxt = 4'b0000;
                    w_valid_nxt  = 1'b0;
                    w_state_nxt  = IDLE;
                end
            end
            default: begin
                w_onehot_nxt = 4'b0000;
                w_valid_nxt  = 1'b0;
                w_hold_nxt   = '0;
                w_state_nxt  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_hold   <= '0;
            r_onehot <= 4'b0000;
            r_valid  <= 1'b0;
            r_wr     <= '0;
            r_rd     <= '0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_hold   <= w_hold_nxt;
            r_onehot <= w_onehot_nxt;
            r_valid  <= w_valid_nxt;
            if (w_push) begin
                r_wr <= r_wr + PW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload needs no reset: pointers and count decide what is ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= in_code;
        end
    end

endmodule

// File: tb/tb_priority_decoder_q.sv
module tb_priority_decoder_q;

    localparam int DEPTH = 4;
    localparam int HOLD  = 3;

    logic                   clk;
    logic                   rst;
    logic [1:0]             in_code;
    logic                   in_valid;
    logic                   in_ready;
    logic [3:0]             out_onehot;
    logic                   out_valid;
    logic [$clog2(DEPTH):0] fifo_count;

    priority_decoder_q #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_code    (in_code),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_onehot (out_onehot),
        .out_valid  (out_valid),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] code;
        int         cyc;
    } ent_t;

    // Reference model: codes accepted but not yet started on the output,
    // each tagged with the edge number at which it was accepted.
    ent_t q[$];
    int   cyc      = 0;
    bit   flush    = 1'b0;
    bit   bp_seen  = 1'b0;
    int   run      = 0;
    logic [1:0] cur = 2'b00;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Acceptance tracking on the active edge (reads pre-edge values).
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            flush = 1'b1;
        end else if (in_valid && in_ready) begin
            q.push_back('{code: in_code, cyc: cyc});
        end
    end

    // Monitor on the opposite edge.
    always @(negedge clk) begin
        if (flush) begin
            chk(out_valid == 1'b0, "rst_valid", 32'(out_valid), 0);
            chk(out_onehot == 4'b0000, "rst_onehot", 32'(out_onehot), 0);
            chk(fifo_count == 0, "rst_count", 32'(fifo_count), 0);
            chk(in_ready == !rst, "rst_ready", 32'(in_ready), 32'(!rst));
            run   = 0;
            flush = 1'b0;
        end else begin
            if (out_valid) begin
                if (run == 0 || run == HOLD) begin
                    if (q.size() == 0) begin
                        chk(1'b0, "spurious_out", 32'(out_onehot), 0);
                        run = HOLD;
                    end else begin
                        ent_t e;
                        e = q.pop_front();
                        chk(e.cyc < cyc, "early_out", 32'(cyc), 32'(e.cyc + 1));
                        chk(out_onehot == 4'(1 << e.code), "onehot_new",
                            32'(out_onehot), 32'(4'(1 << e.code)));
                        cur = e.code;
                        run = 1;
                    end
                end else begin
                    chk(out_onehot == 4'(1 << cur), "onehot_hold",
                        32'(out_onehot), 32'(4'(1 << cur)));
                    run++;
                end
            end else begin
                chk(out_onehot == 4'b0000, "idle_onehot", 32'(out_onehot), 0);
                if (run != 0) chk(run == HOLD, "hold_len", 32'(run), HOLD);
                run = 0;
                if (q.size() > 0)
                    chk(q[0].cyc >= cyc, "stall", 32'(cyc), 32'(q[0].cyc + 1));
            end
            chk(fifo_count == q.size(), "fifo_count", 32'(fifo_count), 32'(q.size()));
            chk(in_ready == ((q.size() < DEPTH) && !rst), "in_ready",
                32'(in_ready), 32'((q.size() < DEPTH) && !rst));
            if (q.size() == DEPTH) bp_seen = 1'b1;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c);
        bit r;
        int n;
        in_code  = c;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!r && n < 200);
        if (!r) chk(1'b0, "send_timeout", 32'(n), 0);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(n < 500, "drain_timeout", 32'(n), 500);
        idle(2);
    endtask

    initial begin
        int k;
        logic [1:0] pat [4];
        pat[0] = 2'b11; pat[1] = 2'b00; pat[2] = 2'b10; pat[3] = 2'b01;

        // Reset with a valid code presented: nothing must be taken.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_code  = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        idle(8);

        // Single code.
        send(2'b10);
        idle(8);

        // Burst with backpressure.
        bp_seen = 1'b0;
        send(2'b00); send(2'b01); send(2'b10); send(2'b11); send(2'b00); send(2'b01);
        drain();
        chk(bp_seen, "backpressure", 32'(bp_seen), 1);

        // Wrap-around stream.
        for (int i = 0; i < 12; i++) send(pat[i % 4]);
        drain();

        // Push lands on the same edge as a DRIVE-expiry pop.
        send(2'b00);
        send(2'b11);
        idle(2);
        send(2'b01);
        drain();

        // Duplicate codes back to back.
        send(2'b10); send(2'b10); send(2'b10);
        drain();

        // Reset in the middle of a DRIVE window with three codes queued.
        send(2'b00); send(2'b01); send(2'b10); send(2'b11);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(12);

        // Randomized traffic with random gaps.
        for (int i = 0; i < 150; i++) begin
            send(2'($urandom_range(0, 3)));
            k = $urandom_range(0, 4);
            if (k > 2) idle(k - 2);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/priority_decoder_q.md
# priority_decoder_q

Queued 2-to-4 priority-code decoder. It is the consumer side of the 4-to-2 priority encoder path:
- It accepts 2-bit encoded indices over a valid/ready handshake and buffers them in a small FIFO.
- It replays each index as a one-hot line held for a fixed number of cycles.
- Typical placement: behind the encoder, driving per-channel strobes or grant lines that must be visible for several cycles and never overlap.

## Interface
- DEPTH, default 4: FIFO entries. Must be a power of 2 and ≥ 2.
- HOLD, default 3: cycles each decoded one-hot value stays asserted. Must be ≥ 1.
- clk, input, 1: single clock. All logic is rising-edge.
- rst, input, 1: synchronous active-high reset, sampled on the rising edge of clk.
- in_code, input, 2: encoded index. 2'b00 → line 0 … 2'b11 → line 3.
- in_valid, input, 1: in_code is valid. Connects directly to the encoder's valid flag.
- in_ready, output, 1: FIFO can accept a code. Transfer happens at an edge where in_valid & in_ready.
- out_onehot, output, 4: decoded line, with exactly one bit set when out_valid is high, else 4'b0000.
- out_valid, output, 1: out_onehot is driving a code.
- fifo_count, output, $clog2(DEPTH)+1: entries currently queued, excluding the entry being driven.

## Operation
- FIFO
  - Circular buffer of DEPTH×2 bits with read and write pointers that wrap modulo DEPTH.
  - in_ready = (fifo_count < DEPTH) & ~rst.
  - in_ready does not look ahead to a same-cycle pop: when full, in_ready stays 0 even if a pop happens on that edge.
- Push: at an edge with in_valid & in_ready, in_code is written at the write pointer and the write pointer advances.
- Pop: at an edge where the FIFO is non-empty and the FSM requests the next code (see below), the head is loaded into the output register and the read pointer advances.
- fifo_count update: +1 on push only, −1 on pop only, unchanged on simultaneous push+pop.
- FSM, two states, registered:
  - IDLE
    - out_valid=0, out_onehot=0.
    - If fifo_count>0: pop, set out_onehot=1<<head, out_valid=1, hold_cnt=HOLD−1, go to DRIVE.
  - DRIVE
    - If hold_cnt>0: decrement it and hold the outputs.
    - If hold_cnt==0 and fifo_count>0: pop the next code immediately (no gap cycle), reload hold_cnt=HOLD−1, stay in DRIVE.
    - If hold_cnt==0 and FIFO empty: clear outputs, go to IDLE.
- Decoding is purely from the stored code. Duplicate consecutive codes still produce separate HOLD-cycle windows, contiguous with no deassertion between them.
- Reset (any time, including mid-DRIVE)
  - Clears state to IDLE, hold_cnt=0, both pointers=0, fifo_count=0, out_onehot=4'b0000, out_valid=0.
  - Queued and in-flight codes are discarded.
  - No push is accepted at an edge where rst=1.

## Timing
- Reset values: out_onehot=0, out_valid=0, fifo_count=0, in_ready=0 while rst is high and 1 in the first cycle after release.
- Latency: a code accepted at edge t into an empty, idle block appears on out_onehot after edge t+1. This is one cycle in the FIFO, then the IDLE pop.
- Each code is asserted for exactly HOLD consecutive cycles.
- Back-to-back codes are gap-free.
- Steady-state throughput is one code per HOLD cycles. When the input rate exceeds this, in_ready backpressures.
- Maximum codes held in the block: DEPTH queued + 1 driven.
- All outputs are registered except in_ready, which is combinational from fifo_count and rst.

## Test plan
- Reset: hold rst for 3 cycles with in_valid=1, in_code=2'b11 → out_onehot=0, out_valid=0, fifo_count=0, in_ready=0 throughout, and no code is emitted after release.
- Single code: push 2'b10 at edge t → out_onehot=4'b0100 with out_valid=1 for cycles t+1..t+3 (HOLD=3), then 0000 and out_valid=0.
- Burst and backpressure: push 00,01,10,11,00,01 on consecutive cycles, holding each until accepted.
  - in_ready drops when fifo_count=4.
  - The held code is accepted once space frees.
  - Output is 0001,0010,0100,1000,0001,0010, each for exactly 3 cycles with no gaps.
- Wrap-around: stream 12 codes (pattern 11,00,10,01 repeated) with in_valid held → output order identical to input, pointers wrap past DEPTH, fifo_count never exceeds 4.
- Simultaneous push/pop: push 2'b01 on the same edge that a DRIVE expiry pops the head → fifo_count unchanged, and the new code is emitted in order after the queued ones.
- Reset mid-operation: assert rst during cycle 2 of a DRIVE with 3 codes queued → next cycle out_onehot=0, out_valid=0, fifo_count=0, and none of the discarded codes appear after release.
